// File: rtl/fa_bist_pkg.sv
// Shared types and constants for the full_adder BIST: FSM state encoding,
// the {A,B,Cin} vector type and the number of vectors in one sweep.
package fa_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        CHECK,
        DONE
    } fa_bist_state_t;

    typedef logic [2:0] fa_vec_t;

    localparam int FA_NUM_VECS = 8;

endpackage

// File: rtl/fa_bist_golden.sv
// Golden full-adder reference: maps an {A,B,Cin} vector to the expected
// sum and carry, kept separate so it can be exercised on its own.
module fa_bist_golden
    import fa_bist_pkg::*;
(
    input  fa_vec_t vec,
    output logic    exp_s,
    output logic    exp_c
);

    logic a, b, cin;

    assign {a, b, cin} = vec;
    assign exp_s = a ^ b ^ cin;
    assign exp_c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder_bist.sv
// Response-checking BIST for a full_adder cell: sweeps all {A,B,Cin} vectors
// PASSES times and reports pass, error count and first failing vector.
// Optional FA_BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module full_adder_bist
    import fa_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int ERR_CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 fa_a,
    output logic                 fa_b,
    output logic                 fa_cin,
    input  logic                 fa_s,
    input  logic                 fa_cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [2:0]           fail_vec
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int PASS_W   = $clog2(PASSES + 1);

    fa_bist_state_t      state;
    fa_vec_t             vec;
    logic [PASS_W-1:0]   pass_idx;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                exp_s;
    logic                exp_c;
    logic                mismatch;
    logic                last_vec;
    logic                end_run;

    fa_bist_golden u_golden (
        .vec   (vec),
        .exp_s (exp_s),
        .exp_c (exp_c)
    );

    // Case-inequality so X/Z from the cell under test is treated as a failure.
    assign mismatch = ({fa_s, fa_cout} !== {exp_s, exp_c});
    assign last_vec = (vec == fa_vec_t'(FA_NUM_VECS - 1)) &&
                      (pass_idx == PASS_W'(PASSES - 1));

`ifdef FA_BIST_STOP_ON_FAIL_EN
    assign end_run = last_vec || mismatch;
`else
    assign end_run = last_vec;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            pass_idx   <= '0;
            settle_cnt <= '0;
            fa_a       <= 1'b0;
            fa_b       <= 1'b0;
            fa_cin     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_vec   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err_cnt  <= '0;
                        fail_vec <= '0;
                        pass     <= 1'b0;
                        vec      <= '0;
                        pass_idx <= '0;
                        busy     <= 1'b1;
                        state    <= APPLY;
                    end
                end
                APPLY: begin
                    {fa_a, fa_b, fa_cin} <= vec;
                    settle_cnt           <= '0;
                    state                <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_W'(1);
                    end
                end
                CHECK: begin
                    // err_cnt never returns to zero mid-run, so zero marks the first failure.
                    if (mismatch) begin
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + ERR_CNT_W'(1);
                        end
                        if (err_cnt == '0) begin
                            fail_vec <= vec;
                        end
                    end
                    if (end_run) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        vec <= vec + fa_vec_t'(1);
                        if (vec == fa_vec_t'(FA_NUM_VECS - 1)) begin
                            pass_idx <= pass_idx + PASS_W'(1);
                        end
                        state <= APPLY;
                    end
                end
                DONE: begin
                    done                 <= 1'b1;
                    pass                 <= (err_cnt == '0);
                    {fa_a, fa_b, fa_cin} <= 3'b000;
                    state                <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_full_adder_bist.sv
// Self-checking bench for full_adder_bist: a behavioural cell with injectable
// faults feeds two BIST instances (PASSES=1 and PASSES=2).
module tb_full_adder_bist;

    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0, start2 = 1'b0;
    logic a1, b1, c1, s1, co1, busy1, done1, pass1;
    logic a2, b2, c2, s2, co2, busy2, done2, pass2;
    logic [3:0] err1, err2;
    logic [2:0] fv1, fv2;

    int mode = 0;
    logic [15:0] flip = '0;
    int sel = 0;
    int checks = 0;
    int errors = 0;

    logic o_busy, o_done, o_pass;
    logic [3:0] o_err;
    logic [2:0] o_fv, o_fa;

    always #5 clk = ~clk;

    // Cell under test: correct adder plus fault modes (1:S sa0, 2:Cout inv, 3:S sa1, 4:random flips).
    function automatic logic [1:0] fa_model(input int m, input logic [15:0] f, input logic [2:0] v);
        int sum;
        logic s, co;
        sum = int'(v[2]) + int'(v[1]) + int'(v[0]);
        s = (sum % 2) == 1;
        co = (sum / 2) == 1;
        case (m)
            1: s = 1'b0;
            2: co = ~co;
            3: s = 1'b1;
            4: begin
                s  = s ^ f[2*v+1];
                co = co ^ f[2*v];
            end
            default: ;
        endcase
        return {s, co};
    endfunction

    always_comb {s1, co1} = fa_model(mode, flip, {a1, b1, c1});
    always_comb {s2, co2} = fa_model(mode, flip, {a2, b2, c2});

    always_comb begin
        if (sel == 1) begin
            o_busy = busy2; o_done = done2; o_pass = pass2;
            o_err = err2; o_fv = fv2; o_fa = {a2, b2, c2};
        end else begin
            o_busy = busy1; o_done = done1; o_pass = pass1;
            o_err = err1; o_fv = fv1; o_fa = {a1, b1, c1};
        end
    end

    full_adder_bist dut (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .fa_a(a1), .fa_b(b1), .fa_cin(c1), .fa_s(s1), .fa_cout(co1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fv1)
    );

    full_adder_bist #(.SETTLE_CYCLES(2), .PASSES(2), .ERR_CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .fa_a(a2), .fa_b(b2), .fa_cin(c2), .fa_s(s2), .fa_cout(co2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .fail_vec(fv2)
    );

    // Reference: sweep vectors arithmetically, compare against the faulty cell, count and time.
    function automatic void ref_run(input int m, input logic [15:0] f, input int passes,
                                    output int err, output int fvec, output bit ok, output int lat);
        int n;
        int sum;
        bit stop;
        logic [1:0] got;
        n = 0; err = 0; fvec = 0; stop = 0;
        for (int p = 0; p < passes; p++) begin
            for (int v = 0; v < 8; v++) begin
                if (!stop) begin
                    sum = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
                    got = fa_model(m, f, 3'(v));
                    n++;
                    if (got !== {1'(sum % 2), 1'(sum / 2)}) begin
                        if (err == 0) fvec = v;
                        if (err < 15) err++;
`ifdef FA_BIST_STOP_ON_FAIL_EN
                        stop = 1;
`endif
                    end
                end
            end
        end
        ok = (err == 0);
        lat = 1 + n * (SETTLE + 2);
    endfunction

    // One full run; inj >= 0 pulses start at that cycle, -2 pulses it during DONE.
    task automatic run_bist(input int s, input int m, input logic [15:0] f, input int inj, input string name);
        int e, fv, lat, cycles, busy_cnt, injc;
        bit ok;
        sel = s; mode = m; flip = f;
        ref_run(m, f, (s == 1) ? 2 : 1, e, fv, ok, lat);
        injc = (inj == -2) ? lat - 1 : inj;
        @(negedge clk);
        if (s == 1) start2 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start2 = 1'b0;
        cycles = 0;
        busy_cnt = int'(o_busy);
        while (!o_done && cycles < 500) begin
            if (s == 1) start2 = (cycles == injc); else start1 = (cycles == injc);
            @(posedge clk); #1;
            cycles++;
            busy_cnt += int'(o_busy);
        end
        start1 = 1'b0; start2 = 1'b0;
        checks++;
        if (cycles !== lat) begin
            errors++; $display("[TB] FAIL %s latency: got %0d expected %0d", name, cycles, lat);
        end
        checks++;
        if (busy_cnt !== lat - 1) begin
            errors++; $display("[TB] FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, lat - 1);
        end
        checks++;
        if (o_err !== 4'(e)) begin
            errors++; $display("[TB] FAIL %s err_cnt: got %0d expected %0d", name, o_err, e);
        end
        checks++;
        if (o_pass !== ok) begin
            errors++; $display("[TB] FAIL %s pass: got %b expected %b", name, o_pass, ok);
        end
        checks++;
        if (o_fv !== 3'(fv)) begin
            errors++; $display("[TB] FAIL %s fail_vec: got %b expected %b", name, o_fv, 3'(fv));
        end
        checks++;
        if (o_fa !== 3'b000) begin
            errors++; $display("[TB] FAIL %s fa_inputs_at_done: got %b expected 000", name, o_fa);
        end
        @(posedge clk); #1;
        checks++;
        if ({o_done, o_busy} !== 2'b00) begin
            errors++; $display("[TB] FAIL %s after_done {done,busy}: got %b expected 00", name, {o_done, o_busy});
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy1, done1, pass1, err1, fv1, a1, b1, c1} !== '0) begin
            errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", {busy1, done1, pass1, err1, fv1, a1, b1, c1});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_faults();
        run_bist(0, 0, '0, -1, "good_cell");
        run_bist(0, 1, '0, -1, "s_stuck0");
        run_bist(0, 3, '0, -1, "s_stuck1");
        run_bist(0, 2, '0, -1, "cout_inv");
    endtask

    task automatic test_back_to_back();
        run_bist(0, 0, '0, int'($urandom_range(1, 30)), "start_while_busy");
        run_bist(0, 0, '0, -2, "start_in_done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_bist(i % 2, int'($urandom_range(0, 4)), 16'($urandom),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : -1, "random_run");
        end
    endtask

    task automatic test_saturation();
        run_bist(1, 2, '0, -1, "two_pass_cout_inv");
        run_bist(1, 0, '0, -1, "two_pass_good");
    endtask

    task automatic test_reset_midrun();
        int seen;
        sel = 0; mode = 1;
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy1, done1, pass1, err1, fv1, a1, b1, c1} !== '0) begin
            errors++; $display("[TB] FAIL midrun_reset_outputs: got %h expected 0", {busy1, done1, pass1, err1, fv1, a1, b1, c1});
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            seen += int'(done1);
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("[TB] FAIL midrun_no_done: got %0d pulses expected 0", seen);
        end
        run_bist(0, 0, '0, -1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_faults();
        test_back_to_back();
        test_random();
        test_saturation();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
